// File: rtl/task_1.sv
// Registered single-digit seven-segment decoder, active-high segments {g,f,e,d,c,b,a}.
// Define TASK1_HEX_EN to show hex glyphs A..F for inputs 10..15; otherwise those inputs blank.
module task_1 (
  input  logic       i_w_clk,
  input  logic       i_w_rst_n,
  input  logic [3:0] i_w_in,
  output logic [6:0] o_w_7seg
);

  logic [6:0] seg_d;
  logic [6:0] seg_q;

  // Unmatched values, including X/Z in simulation, fall through to blank.
  always_comb begin
    seg_d = 7'h00;
    case (i_w_in)
      4'd0:    seg_d = 7'h3F;
      4'd1:    seg_d = 7'h06;
      4'd2:    seg_d = 7'h5B;
      4'd3:    seg_d = 7'h4F;
      4'd4:    seg_d = 7'h66;
      4'd5:    seg_d = 7'h6D;
      4'd6:    seg_d = 7'h7D;
      4'd7:    seg_d = 7'h07;
      4'd8:    seg_d = 7'h7F;
      4'd9:    seg_d = 7'h6F;
`ifdef TASK1_HEX_EN
      4'd10:   seg_d = 7'h77;
      4'd11:   seg_d = 7'h7C;
      4'd12:   seg_d = 7'h39;
      4'd13:   seg_d = 7'h5E;
      4'd14:   seg_d = 7'h79;
      4'd15:   seg_d = 7'h71;
`endif
      default: seg_d = 7'h00;
    endcase
  end

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      seg_q <= 7'h00;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign o_w_7seg = seg_q;

endmodule

// File: tb/tb_task_1.sv
// Directed bench for task_1: reset, async reset, decimal/non-decimal sweeps, latency.
module tb_task_1;

  logic       clk;
  logic       rst_n;
  logic [3:0] din;
  logic [6:0] seg;

  int n_chk  = 0;
  int n_fail = 0;
  logic [6:0] exp_q[$];

  task_1 dut (
    .i_w_clk   (clk),
    .i_w_rst_n (rst_n),
    .i_w_in    (din),
    .o_w_7seg  (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    logic [6:0] tbl [16];
    tbl = '{7'd63, 7'd6, 7'd91, 7'd79, 7'd102, 7'd109, 7'd125, 7'd7,
            7'd127, 7'd111,
`ifdef TASK1_HEX_EN
            7'd119, 7'd124, 7'd57, 7'd94, 7'd121, 7'd113};
`else
            7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
`endif
    return tbl[v];
  endfunction

  task automatic check(input string tag, input logic [6:0] expv);
    n_chk++;
    assert (seg === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, seg, expv);
    end
  endtask

  task automatic check_pop(input string tag);
    logic [6:0] e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s observed=%0d expected=<empty scoreboard>", tag, seg);
    end else begin
      e = exp_q.pop_front();
      check(tag, e);
    end
  endtask

  // Drive on the falling edge, compare just after the next rising edge.
  task automatic step(input logic [3:0] v, input string tag);
    @(negedge clk);
    din = v;
    exp_q.push_back(ref_seg(v));
    @(posedge clk);
    #1;
    check_pop(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    din   = 4'd8;
    #1;
    check("reset_immediate", 7'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", 7'd0);
    end

    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(7'd127);
    @(posedge clk);
    #1;
    check_pop("reset_release");

    for (int v = 0; v < 10; v++) step(4'(v), "dec_sweep");

    step(4'd1, "latency_pre");
    @(negedge clk);
    din = 4'd7;
    exp_q.push_back(7'd7);
    #1;
    check("latency_hold", 7'd6);
    @(posedge clk);
    #1;
    check_pop("latency_update");

    step(4'd0, "async_pre");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset", 7'd0);
    @(posedge clk);
    #1;
    check("async_hold", 7'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'd3, "async_release");

    for (int v = 10; v < 16; v++) step(4'(v), "nondec_sweep");

    for (int i = 0; i < 20; i++) step(4'($urandom_range(0, 15)), "random");

    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/task_1.md
# task_1

Single-digit seven-segment display decoder. Converts a 4-bit value into the segment pattern for one digit and drives it from a register, so the display lines are glitch-free. Sits between the value source (counter, switches, datapath register) and the display pins. Each instance drives one digit; multi-digit displays use one instance per digit.

## Interface
Parameters:
- none. Behaviour is fixed except for the single compile-time option in Configuration.

Ports:
- i_w_clk  input  1  system clock. All state updates on the rising edge.
- i_w_rst_n  input  1  reset. Asynchronous, active-low.
- i_w_in  input  4  value to display, unsigned, 0..15.
- o_w_7seg  output  7  segment drive. Active-high (1 = segment lit). Bit mapping {g,f,e,d,c,b,a}: bit0 = a, bit6 = g.

## Operation
- Combinational lookup of i_w_in, registered into o_w_7seg on every clock edge. No enable and no handshake.
- Required decimal patterns (o_w_7seg value, decimal):
  - 0 -> 63 (0x3F)
  - 1 -> 6 (0x06)
  - 2 -> 91 (0x5B)
  - 3 -> 79 (0x4F)
  - 4 -> 102 (0x66)
  - 5 -> 109 (0x6D)
  - 6 -> 125 (0x7D)
  - 7 -> 7 (0x07)
  - 8 -> 127 (0x7F)
  - 9 -> 111 (0x6F)
- Inputs 10..15 are handled as defined in Configuration.
- X or Z on any bit of i_w_in produces 0 (blank). The decoder never propagates X to its output.
- Segment polarity is fixed active-high. Boards with common-anode displays invert outside this block.

## Timing
- Reset: while i_w_rst_n = 0, o_w_7seg = 0 (all segments off). This takes effect immediately, without waiting for a clock edge.
- Reset release: the first rising edge with i_w_rst_n = 1 loads the decoded pattern of the current i_w_in.
- Latency: exactly 1 clock. The value of i_w_in sampled at edge N appears on o_w_7seg after edge N and holds until edge N+1.
- Back-to-back input changes on consecutive cycles are each reflected, one cycle later.
- A change of i_w_in between edges has no effect on the output until the next edge.
- Reset asserted mid-operation blanks the output immediately. No other state exists.

## Configuration
- Macro: TASK1_HEX_EN.
- Defined: inputs 10..15 show hex glyphs:
  - A -> 0x77
  - b -> 0x7C
  - C -> 0x39
  - d -> 0x5E
  - E -> 0x79
  - F -> 0x71
- Not defined (default): inputs 10..15 produce 0 (blank). Patterns for 0..9 are identical in both builds.

## Test plan
- Reset: hold i_w_rst_n = 0 with i_w_in = 8 for 3 clocks -> o_w_7seg = 0 throughout. Release reset -> 127 after the first edge.
- Async reset: assert i_w_rst_n low midway between clock edges while the output shows 63 -> o_w_7seg = 0 before the next edge.
- Decimal sweep: i_w_in = 0..9, one value per clock -> o_w_7seg = 63, 6, 91, 79, 102, 109, 125, 7, 127, 111, each appearing one cycle after its input.
- Latency: change i_w_in from 1 to 7 halfway between edges -> output stays 6 until the next rising edge, then becomes 7.
- Non-decimal inputs without TASK1_HEX_EN: i_w_in = 10..15 -> 0 each.
- Non-decimal inputs with TASK1_HEX_EN: i_w_in = 10..15 -> 119, 124, 57, 94, 121, 113.
